// File: rtl/cpu_input_arbiter_if.sv
// Request/data bundle between the peripherals, the arbiter and the CPU input port.
// master: the arbiter (samples requests, drives ack and the CPU-side strobe/data).
// slave: the peripheral/CPU side (drives requests, observes grant results).
interface cpu_input_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0][BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                ack;
  logic [BUS_WIDTH-1:0]              in_port;
  logic                              ready_in;
  logic [ID_W-1:0]                   grant_id;
  logic                              busy;

  modport master (
    input  req, req_data,
    output ack, in_port, ready_in, grant_id, busy
  );

  modport slave (
    output req, req_data,
    input  ack, in_port, ready_in, grant_id, busy
  );
endinterface

// File: rtl/cpu_input_arbiter.sv
// Round-robin share of the CPU in_port/ready_in channel between NUM_REQ sources.
// Latency: data on in_port at the grant edge, ready_in one edge later for HOLD_CYCLES, ack after.
// Backpressure: a requester holds req until its one-cycle ack; only IDLE arbitrates.
module cpu_input_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4
) (
  input logic                 clk,
  input logic                 n_reset,
  cpu_input_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ASSERT, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, rr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BUS_WIDTH-1:0] in_port_q, in_port_nxt;
  logic                 ready_q, ready_nxt;
  logic [NUM_REQ-1:0]   ack_q, ack_nxt;
  logic [ID_W-1:0]      grant_q, grant_nxt;
  logic                 busy_q, busy_nxt;

  logic                 found;
  logic [ID_W-1:0]      pick;
  logic [ID_W:0]        sum;

  // Round-robin search: first set req starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req[sum[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a state changes it.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    cnt_nxt     = cnt;
    in_port_nxt = in_port_q;
    ready_nxt   = ready_q;
    ack_nxt     = ack_q;
    grant_nxt   = grant_q;
    busy_nxt    = busy_q;
    case (state)
      IDLE: begin
        if (found) begin
          in_port_nxt = bus.req_data[pick];
          grant_nxt   = pick;
          busy_nxt    = 1'b1;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        // Data has been stable for a full cycle before the strobe rises.
        ready_nxt = 1'b1;
        cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        state_nxt = ASSERT;
      end
      ASSERT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          ready_nxt         = 1'b0;
          ack_nxt           = '0;
          ack_nxt[grant_q]  = 1'b1;
          state_nxt         = RELEASE;
        end
      end
      RELEASE: begin
        ack_nxt   = '0;
        rr_nxt    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer without an ack.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      in_port_q <= '0;
      ready_q   <= 1'b0;
      ack_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      cnt       <= cnt_nxt;
      in_port_q <= in_port_nxt;
      ready_q   <= ready_nxt;
      ack_q     <= ack_nxt;
      grant_q   <= grant_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign bus.in_port  = in_port_q;
  assign bus.ready_in = ready_q;
  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
endmodule
